// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM state encoding and BCD digit limits.
package stopwatch_pkg;

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  localparam int unsigned         BCD_W        = 4;
  localparam logic [BCD_W-1:0]    SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0]    DIGIT_MAX    = 4'd9;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Button-pulse inputs and registered display/status outputs of the stopwatch core.
interface stopwatch_core_if
  import stopwatch_pkg::*;
;
  logic             pause_pulse;
  logic             clear_pulse;
  logic [BCD_W-1:0] min_tens;
  logic [BCD_W-1:0] min_ones;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic             running;
  logic             sec_tick;
  logic             rollover;
  logic             blank;

  modport master (
    output pause_pulse, clear_pulse,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  running, sec_tick, rollover, blank
  );

  modport slave (
    input  pause_pulse, clear_pulse,
    output min_tens, min_ones, sec_tens, sec_ones,
    output running, sec_tick, rollover, blank
  );

endinterface

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit counting 0..MAX; carry is high when an increment wraps the digit back to 0.
module stopwatch_bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIGIT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  logic [BCD_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == MAX) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc && (digit_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Run/pause FSM, 1 Hz prescaler and MM:SS BCD counter driven by debounced button pulses.
// Define PAUSE_BLINK_EN to blink the display (blank output) while paused.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned MAX_MIN = 59
) (
  input  logic           clk,
  input  logic           rst_n,
  stopwatch_core_if.slave sw
);

  localparam int unsigned      PW         = cnt_w(CLK_HZ);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [BCD_W-1:0] MT_MAX     = BCD_W'(MAX_MIN / 10);
  localparam logic [BCD_W-1:0] MO_MAX     = BCD_W'(MAX_MIN % 10);

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             sec_tick_q, rollover_q;
  logic             tick, roll, at_max, clr_time;
  logic             so_carry, st_carry, mo_carry, mt_carry;
  logic [BCD_W-1:0] mt, mo, st, so;

  always_comb begin
    state_d = state_q;
    if (sw.pause_pulse) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
  end

  // A clear wins over the wrap: the partial second is discarded and no tick is issued.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (sw.clear_pulse) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign at_max   = (mt == MT_MAX) && (mo == MO_MAX) &&
                    (st == SEC_TENS_MAX) && (so == DIGIT_MAX);
  assign roll     = tick && (at_max || mt_carry);
  assign clr_time = sw.clear_pulse || roll;

  stopwatch_bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .clr(clr_time), .inc(tick),
    .digit(so), .carry(so_carry)
  );

  stopwatch_bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr(clr_time), .inc(so_carry),
    .digit(st), .carry(st_carry)
  );

  stopwatch_bcd_digit #(.MAX(DIGIT_MAX)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .clr(clr_time), .inc(st_carry),
    .digit(mo), .carry(mo_carry)
  );

  stopwatch_bcd_digit #(.MAX(DIGIT_MAX)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .clr(clr_time), .inc(mo_carry),
    .digit(mt), .carry(mt_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PAUSED;
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sec_tick_q <= tick;
      rollover_q <= roll;
    end
  end

  assign sw.min_tens = mt;
  assign sw.min_ones = mo;
  assign sw.sec_tens = st;
  assign sw.sec_ones = so;
  assign sw.running  = (state_q == ST_RUN);
  assign sw.sec_tick = sec_tick_q;
  assign sw.rollover = rollover_q;

`ifdef PAUSE_BLINK_EN
  localparam int unsigned HALF = CLK_HZ / 2;
  localparam int unsigned BW   = cnt_w(HALF);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blank_q, blank_d;

  // Phase restarts on every entry to PAUSED: only count while paused before and after this edge.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blank_d     = blank_q;
    if (sw.clear_pulse || (state_q != ST_PAUSED) || (state_d != ST_PAUSED)) begin
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (blink_cnt_q == BW'(HALF - 1)) begin
      blink_cnt_d = '0;
      blank_d     = ~blank_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign sw.blank = blank_q;
`else
  assign sw.blank = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: a seconds-level reference model predicts each cycle's outputs.
module tb_stopwatch_core;

  localparam int unsigned CLK_HZ  = 4;
  localparam int unsigned MAX_MIN = 59;
  localparam int          WRAP_S  = (MAX_MIN + 1) * 60;

  typedef struct packed {
    logic [3:0] mt, mo, st, so;
    logic       run, tick, roll, blank;
  } out_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  stopwatch_core_if sw ();

  stopwatch_core #(.CLK_HZ(CLK_HZ), .MAX_MIN(MAX_MIN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw)
  );

  always #5 clk = ~clk;

  // Reference model: whole seconds elapsed, cycles into the current second, run flag,
  // and cycles spent continuously paused (for the blink phase).
  bit m_run;
  int m_phase, m_secs, m_pcnt;

  out_t exp_q[$];
  out_t tick_q[$];

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned tick_seen = 0, roll_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic out_t dut_out();
    return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones,
            sw.running, sw.sec_tick, sw.rollover, sw.blank};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
  endfunction

  function automatic void model_reset();
    m_run = 0; m_phase = 0; m_secs = 0; m_pcnt = 0;
  endfunction

  function automatic out_t model_step(input bit p, input bit c);
    out_t e;
    bit tick, roll, was_paused;
    int m, s;
    was_paused = !m_run;
    tick = m_run && (m_phase == CLK_HZ - 1) && !c;
    roll = 0;
    if (c) begin
      m_phase = 0;
      m_secs  = 0;
    end else if (m_run) begin
      m_phase = (m_phase + 1) % CLK_HZ;
    end
    if (tick) begin
      m_secs = (m_secs + 1) % WRAP_S;
      roll   = (m_secs == 0);
    end
    if (p) m_run = !m_run;
    if (was_paused && !m_run && !c) m_pcnt++;
    else m_pcnt = 0;
    m = m_secs / 60;
    s = m_secs % 60;
    e.mt   = 4'(m / 10);
    e.mo   = 4'(m % 10);
    e.st   = 4'(s / 10);
    e.so   = 4'(s % 10);
    e.run  = m_run;
    e.tick = tick;
    e.roll = roll;
`ifdef PAUSE_BLINK_EN
    e.blank = !m_run && (((m_pcnt / (CLK_HZ / 2)) % 2) == 1);
`else
    e.blank = 1'b0;
`endif
    return e;
  endfunction

  // Apply one cycle of inputs at a negedge; the prediction is for the outputs after the next posedge.
  task automatic cycle(input bit p, input bit c);
    out_t e;
    sw.pause_pulse = p;
    sw.clear_pulse = c;
    e = model_step(p, c);
    exp_q.push_back(e);
    if (e.tick) tick_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rand_cycle();
    bit p, c;
    p = ($urandom_range(0, 39) == 0);
    c = ($urandom_range(0, 59) == 0);
    if ($urandom_range(0, 199) == 0) begin
      p = 1;
      c = 1;
    end
    cycle(p, c);
  endtask

  always @(posedge clk) begin
    out_t got, e;
    #1;
    if (rst_n) begin
      got = dut_out();
      if (exp_q.size() == 0) begin
        check("no_expectation", 32'(got), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("cycle_outputs", 32'(got), 32'(e));
      end
      if (sw.sec_tick) begin
        tick_seen++;
        if (sw.rollover) roll_seen++;
        if (tick_q.size() == 0) begin
          check("unexpected_tick", 32'(got), 32'h0);
        end else begin
          e = tick_q.pop_front();
          check("tick_time", {15'h0, got.roll, dut_digits()}, {15'h0, e.roll, e.mt, e.mo, e.st, e.so});
        end
      end
    end
  end

  initial begin
    int n;
    bit seen, reached;
    sw.pause_pulse = 1'b0;
    sw.clear_pulse = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", 32'(dut_out()), 32'h0);
    rst_n = 1'b1;

    repeat (40) cycle(0, 0);
    check("idle_outputs", 32'(dut_out()), 32'h0);
    check("idle_ticks", tick_seen, 0);

    cycle(1, 0);
    check("run_rise", 32'(sw.running), 32'h1);
    repeat (40) cycle(0, 0);
    check("disp_00_10", 32'(dut_digits()), 32'h0010);
    check("ten_ticks", tick_seen, 10);

    repeat (3589 * CLK_HZ) cycle(0, 0);
    check("disp_59_59", 32'(dut_digits()), 32'h5959);
    repeat (CLK_HZ) cycle(0, 0);
    check("wrap_00_00", 32'(dut_digits()), 32'h0000);
    check("one_rollover", roll_seen, 1);

    cycle(0, 1);
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (m_secs == 7 && m_phase == 1) reached = 1;
      else cycle(0, 0);
    end
    check("reach_07_p1", 32'(reached), 32'h1);
    cycle(1, 0);
    repeat (20) cycle(0, 0);
    check("hold_07_paused", {15'h0, sw.running, dut_digits()}, 32'h0007);
    cycle(1, 0);
    check("resume_run", 32'(sw.running), 32'h1);
    n = 0;
    seen = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      cycle(0, 0);
      if (sw.sec_tick) begin
        seen = 1;
        n = i;
      end
    end
    check("resume_tick_latency", 32'(n), 32'd2);

    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (m_run && m_secs == 9 && m_phase == CLK_HZ - 1) reached = 1;
      else cycle(0, 0);
    end
    check("reach_09_wrap", 32'(reached), 32'h1);
    cycle(0, 1);
    check("clear_on_wrap", {14'h0, sw.sec_tick, sw.running, dut_digits()}, 32'h0001_0000);
    cycle(1, 1);
    check("clear_and_pause", {15'h0, sw.running, dut_digits()}, 32'h0);

    repeat (1500) rand_cycle();

    if (!m_run) cycle(1, 0);
    repeat (6) cycle(0, 0);
    sw.pause_pulse = 1'b0;
    sw.clear_pulse = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(dut_out()), 32'h0);
    exp_q.delete();
    tick_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (60) rand_cycle();

    check("exp_drained", exp_q.size(), 0);
    check("ticks_drained", tick_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
